// File: rtl/mac_pkg.sv
// Shared constants and the operand-entry layout for the MAC operand sequencer.
package mac_pkg;

    localparam int OPW        = 4;
    localparam int ACCW       = 11;
    localparam int MAC_LAT    = 3;
    localparam int OVF_THRESH = 10;
    localparam int ENTRY_W    = 2 * OPW + 1;

    typedef struct packed {
        logic [OPW-1:0] a;
        logic [OPW-1:0] b;
        logic           last;
    } operand_t;

endpackage

// File: rtl/mac_operand_fifo.sv
// Synchronous operand FIFO with registered full/empty flags and a
// combinational head so the issue logic can inspect the next entry.
module mac_operand_fifo #(
    parameter int DEPTH   = 8,
    parameter int ENTRY_W = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [ENTRY_W-1:0] push_data,
    input  logic               pop,
    output logic [ENTRY_W-1:0] head,
    output logic               full,
    output logic               empty
);
    import mac_pkg::*;

    localparam int AW = $clog2(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          do_push, do_pop;

    assign do_push = push && !full_q;
    assign do_pop  = pop && !empty_q;

    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        cnt_d    = cnt_q;
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
        full_d  = (cnt_d == (AW+1)'(DEPTH));
        empty_d = (cnt_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    assign head  = mem[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/mac_dot_sequencer.sv
// Feeds operand pairs to a free-running MAC and reports per-vector dot
// products as the difference of two accumulator snapshots.
module mac_dot_sequencer #(
    parameter int DEPTH   = 8,
    parameter int LEN_W   = 4,
    parameter int MAC_LAT = mac_pkg::MAC_LAT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [mac_pkg::OPW-1:0]   in_a,
    input  logic [mac_pkg::OPW-1:0]   in_b,
    input  logic                      in_last,
    output logic [mac_pkg::OPW-1:0]   mac_a,
    output logic [mac_pkg::OPW-1:0]   mac_b,
    input  logic [mac_pkg::ACCW-1:0]  mac_acc,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [mac_pkg::ACCW-1:0]  res_data,
    output logic [LEN_W-1:0]          res_len,
    output logic                      res_ovf
);
    import mac_pkg::*;

    localparam int THR_W = $clog2(OVF_THRESH + 1);
    localparam int LIF_W = $clog2(MAC_LAT + 2);

    typedef struct packed {
        logic             valid;
        logic             first;
        logic             last;
        logic [LEN_W-1:0] len;
        logic             ovf;
    } tag_t;

    typedef struct packed {
        logic [ACCW-1:0]  data;
        logic [LEN_W-1:0] len;
        logic             ovf;
    } res_t;

    operand_t             head;
    logic [ENTRY_W-1:0]   head_bits;
    logic                 fifo_full, fifo_empty;
    logic                 pop;

    logic [OPW-1:0]       mac_a_q, mac_a_d, mac_b_q, mac_b_d;
    logic [LEN_W-1:0]     cnt_q, cnt_d, cnt_inc;
    logic [THR_W-1:0]     thr_q, thr_d, thr_inc;
    logic                 ovf_hit;
    logic                 first_q, first_d;

    tag_t                 tag_in;
    tag_t                 snap_tag;
    logic [MAC_LAT-1:0]   stage_last;
    logic [LIF_W-1:0]     lasts_in_flight;
    logic [LIF_W:0]       credit_used;

    logic                 end_valid_q, end_valid_d;
    logic [LEN_W-1:0]     end_len_q, end_len_d;
    logic                 end_ovf_q, end_ovf_d;
    logic [ACCW-1:0]      snap_q, snap_d;

    res_t                 rq_mem_q [2];
    res_t                 rq_entry;
    logic                 rq_wr_q, rq_wr_d, rq_rd_q, rq_rd_d;
    logic [1:0]           rq_cnt_q, rq_cnt_d;
    logic                 rq_push, rq_pop;

    mac_operand_fifo #(
        .DEPTH   (DEPTH),
        .ENTRY_W (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (in_valid),
        .push_data ({in_a, in_b, in_last}),
        .pop       (pop),
        .head      (head_bits),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign head     = operand_t'(head_bits);
    assign in_ready = !fifo_full;

    // Tag shift register runs in lockstep with the MAC's internal pipeline.
    genvar gi;
    for (gi = 0; gi < MAC_LAT; gi++) begin : g_tag
        tag_t tag_q, tag_d;
        if (gi == 0) begin : g_head
            always_comb tag_d = tag_in;
        end else begin : g_body
            always_comb tag_d = g_tag[gi-1].tag_q;
        end
        always_ff @(posedge clk or posedge rst) begin
            if (rst) tag_q <= '0;
            else     tag_q <= tag_d;
        end
        assign stage_last[gi] = tag_q.valid && tag_q.last;
    end

    assign snap_tag = g_tag[MAC_LAT-1].tag_q;

    always_comb begin
        lasts_in_flight = LIF_W'(end_valid_q);
        for (int i = 0; i < MAC_LAT; i++) begin
            lasts_in_flight = lasts_in_flight + LIF_W'(stage_last[i]);
        end
        credit_used = (LIF_W+1)'(lasts_in_flight) + (LIF_W+1)'(rq_cnt_q);
    end

    // A last may only issue if its result is guaranteed a queue slot.
    always_comb begin
        pop     = !fifo_empty && !(head.last && credit_used >= (LIF_W+1)'(2));
        mac_a_d = pop ? head.a : '0;
        mac_b_d = pop ? head.b : '0;
        cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + LEN_W'(1);
        thr_inc = (thr_q == THR_W'(OVF_THRESH)) ? thr_q : thr_q + THR_W'(1);
        ovf_hit = (thr_inc == THR_W'(OVF_THRESH));
        tag_in  = '0;
        cnt_d   = cnt_q;
        thr_d   = thr_q;
        first_d = first_q;
        if (pop) begin
            tag_in.valid = 1'b1;
            tag_in.first = first_q;
            tag_in.last  = head.last;
            tag_in.len   = cnt_inc;
            tag_in.ovf   = ovf_hit;
            if (head.last) begin
                cnt_d   = '0;
                thr_d   = '0;
                first_d = 1'b1;
            end else begin
                cnt_d   = cnt_inc;
                thr_d   = thr_inc;
                first_d = 1'b0;
            end
        end
    end

    always_comb begin
        snap_d      = (snap_tag.valid && snap_tag.first) ? mac_acc : snap_q;
        end_valid_d = snap_tag.valid && snap_tag.last;
        end_len_d   = snap_tag.len;
        end_ovf_d   = snap_tag.ovf;
    end

    // End sample one cycle after the start stage, when the last pair has landed.
    always_comb begin
        rq_push       = end_valid_q;
        rq_entry.data = mac_acc - snap_q;
        rq_entry.len  = end_len_q;
        rq_entry.ovf  = end_ovf_q;
        rq_pop        = (rq_cnt_q != 2'd0) && res_ready;
        rq_wr_d       = rq_wr_q ^ rq_push;
        rq_rd_d       = rq_rd_q ^ rq_pop;
        rq_cnt_d      = rq_cnt_q + 2'(rq_push) - 2'(rq_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mac_a_q     <= '0;
            mac_b_q     <= '0;
            cnt_q       <= '0;
            thr_q       <= '0;
            first_q     <= 1'b1;
            end_valid_q <= 1'b0;
            end_len_q   <= '0;
            end_ovf_q   <= 1'b0;
            snap_q      <= '0;
            rq_wr_q     <= 1'b0;
            rq_rd_q     <= 1'b0;
            rq_cnt_q    <= '0;
        end else begin
            mac_a_q     <= mac_a_d;
            mac_b_q     <= mac_b_d;
            cnt_q       <= cnt_d;
            thr_q       <= thr_d;
            first_q     <= first_d;
            end_valid_q <= end_valid_d;
            end_len_q   <= end_len_d;
            end_ovf_q   <= end_ovf_d;
            snap_q      <= snap_d;
            rq_wr_q     <= rq_wr_d;
            rq_rd_q     <= rq_rd_d;
            rq_cnt_q    <= rq_cnt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) rq_mem_q[i] <= '0;
        end else if (rq_push) begin
            rq_mem_q[rq_wr_q] <= rq_entry;
        end
    end

    assign mac_a     = mac_a_q;
    assign mac_b     = mac_b_q;
    assign res_valid = (rq_cnt_q != 2'd0);
    assign res_data  = rq_mem_q[rq_rd_q].data;
    assign res_len   = rq_mem_q[rq_rd_q].len;
    assign res_ovf   = rq_mem_q[rq_rd_q].ovf;

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Directed bench for mac_dot_sequencer driving a behavioural 3-stage MAC.
module tb_mac_dot_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_last;
    logic [3:0]  in_a, in_b, mac_a, mac_b;
    logic [10:0] mac_acc, res_data;
    logic        res_valid, res_ready, res_ovf;
    logic [3:0]  res_len;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [15:0] got_q[$];

    mac_dot_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .mac_a     (mac_a),
        .mac_b     (mac_b),
        .mac_acc   (mac_acc),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_len   (res_len),
        .res_ovf   (res_ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // MAC model: pair in cycle k is part of the accumulator from cycle k+3.
    logic [7:0] p1, p2;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            p1      <= '0;
            p2      <= '0;
            mac_acc <= '0;
        end else begin
            p1      <= mac_a * mac_b;
            p2      <= p1;
            mac_acc <= mac_acc + {3'b000, p2};
        end
    end

    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) got_q.push_back({res_ovf, res_len, res_data});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = %0d", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic last);
        logic accepted;
        int   n;
        n        = 0;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        in_valid = 1'b1;
        do begin
            accepted = in_ready;
            tick();
            n++;
        end while (!accepted && n < 100);
        in_valid = 1'b0;
        if (!accepted) check("send_accept", 32'(accepted), 1);
    endtask

    task automatic expect_res(input string tag, input int data, input int len, input int ovf);
        int          n;
        logic [15:0] r;
        n = 0;
        while (got_q.size() == 0 && n < 300) begin
            tick();
            n++;
        end
        check({tag, "_arrived"}, 32'(got_q.size() != 0), 1);
        if (got_q.size() != 0) begin
            r = got_q.pop_front();
            check({tag, "_data"}, 32'(r[10:0]), data);
            check({tag, "_len"},  32'(r[14:11]), len);
            check({tag, "_ovf"},  32'(r[15]), ovf);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, t0, nz;
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; res_ready = 1'b1;
        repeat (3) tick();
        check("rst_in_ready",  32'(in_ready), 1);
        check("rst_res_valid", 32'(res_valid), 0);
        check("rst_mac_a",     32'(mac_a), 0);
        check("rst_res_data",  32'(res_data), 0);
        rst = 1'b0;
        tick();

        // Single pair: result 4 cycles after it reaches the MAC inputs.
        send(4'd3, 4'd5, 1'b1);
        n = 0;
        while (mac_a !== 4'd3 && n < 20) begin tick(); n++; end
        check("t1_mac_a", 32'(mac_a), 3);
        check("t1_mac_b", 32'(mac_b), 5);
        t0 = cyc;
        n = 0;
        while (!res_valid && n < 20) begin tick(); n++; end
        check("t1_latency", 32'(cyc - t0), 4);
        expect_res("t1", 15, 1, 0);

        for (int i = 0; i < 4; i++) send(4'd15, 4'd15, i == 3);
        expect_res("t2", 900, 4, 0);

        // Back-to-back vectors share the boundary snapshot.
        send(4'd2, 4'd3, 1'b0);
        send(4'd4, 4'd4, 1'b1);
        send(4'd1, 4'd7, 1'b1);
        expect_res("t3a", 22, 2, 0);
        expect_res("t3b", 7, 1, 0);
        repeat (4) tick();
        check("t3_acc_total", 32'(mac_acc), 944);

        res_ready = 1'b0;
        send(4'd1, 4'd1, 1'b1);
        send(4'd2, 4'd2, 1'b1);
        send(4'd3, 4'd3, 1'b1);
        repeat (3) tick();
        nz = 0;
        for (int i = 0; i < 10; i++) begin
            if (mac_a != 4'd0) nz++;
            tick();
        end
        check("t4_stall_bubbles", 32'(nz), 0);
        check("t4_res_valid",     32'(res_valid), 1);
        check("t4_head_data",     32'(res_data), 1);
        check("t4_none_taken",    32'(got_q.size()), 0);
        res_ready = 1'b1;
        expect_res("t4a", 1, 1, 0);
        expect_res("t4b", 4, 1, 0);
        expect_res("t4c", 9, 1, 0);

        for (int i = 0; i < 10; i++) send(4'd15, 4'd15, i == 9);
        expect_res("t5_ten", 202, 10, 1);
        for (int i = 0; i < 17; i++) send(4'd15, 4'd15, i == 16);
        expect_res("t5_seventeen", 1777, 15, 1);

        // Fill the FIFO behind a credit-stalled last, then reset mid-vector.
        res_ready = 1'b0;
        send(4'd1, 4'd1, 1'b1);
        send(4'd1, 4'd1, 1'b1);
        repeat (6) tick();
        send(4'd1, 4'd1, 1'b1);
        for (int i = 0; i < 7; i++) send(4'd2, 4'd2, 1'b0);
        check("t6_full_in_ready", 32'(in_ready), 0);
        check("t6_held_valid",    32'(res_valid), 1);
        rst = 1'b1;
        tick();
        check("t6_rst_in_ready",  32'(in_ready), 1);
        check("t6_rst_res_valid", 32'(res_valid), 0);
        check("t6_rst_res_data",  32'(res_data), 0);
        check("t6_rst_res_len",   32'(res_len), 0);
        check("t6_rst_res_ovf",   32'(res_ovf), 0);
        check("t6_rst_mac_a",     32'(mac_a), 0);
        check("t6_rst_mac_b",     32'(mac_b), 0);
        rst = 1'b0;
        got_q.delete();
        res_ready = 1'b1;
        tick();
        send(4'd6, 4'd7, 1'b1);
        expect_res("t6_after_rst", 42, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
